crc_stream_engine: RTL and testbench
====================================

Name: crc_stream_engine

Overview:
- Parametrised successor to the single-bit serial CRC-16 generator.
- Accepts DIN_W-bit beats over a valid/ready handshake and folds BPC bits per clock into a CRC_W-bit register.
- Presents the finalised CRC (reflection and XOR-out applied) on an output handshake at end of frame.
- Sits between framers/deframers and link logic; one instance per channel.

Parameters:
- CRC_W, 16, CRC register width (8..32).
- POLY, 16'h1021, generator polynomial, implicit top bit omitted.
- INIT, 16'hFFFF, register value after init, reset, or completed frame.
- XOROUT, 16'h0000, XOR applied to the finalised CRC.
- DIN_W, 8, beat width in bits.
- BPC, 1, bits processed per clock; DIN_W % BPC == 0 is required (elaboration error otherwise).
- REFIN, 0, 1 = each beat consumed LSB first; 0 = MSB first.
- REFOUT, 0, 1 = finalised CRC bit-reversed before XOROUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  synchronous pulse: reload INIT, abort frame.
- in_valid  in  1  beat valid.
- in_ready  out  1  engine can accept a beat.
- in_data  in  DIN_W  beat payload.
- in_last  in  1  beat is the final beat of the frame.
- crc_valid  out  1  finalised CRC available.
- out_ready  in  1  consumer accepts CRC.
- crc_out  out  CRC_W  finalised CRC.

Behaviour:
- K = DIN_W/BPC.
- States: IDLE, SHIFT, DONE. Beat register, last flag, log2(K)-bit count, CRC register.
- Reset (reset low, asynchronous):
  - state = IDLE, CRC register = INIT, count = 0.
  - in_ready = 0 while reset is low, 1 from the first cycle after release.
  - crc_valid = 0, crc_out = 0.
- init (synchronous) has priority over everything in any state:
  - CRC register = INIT, state = IDLE, pending beat discarded, crc_valid dropped.
  - A beat offered with in_valid in the init cycle is not accepted; in_ready is 0 during init.
- IDLE:
  - in_ready = 1.
  - in_valid & in_ready latches in_data and in_last, count = K-1, next state SHIFT.
- SHIFT:
  - in_ready = 0.
  - Each cycle folds the next BPC bits into the register (MSB first if REFIN = 0, LSB first if REFIN = 1); count decrements.
  - On the cycle with count == 0: next state is DONE if last is set, else IDLE.
  - Back-to-back beats therefore sustain 1 beat per K+1 cycles.
- DONE:
  - crc_valid = 1; crc_out = (REFOUT ? reverse(reg) : reg) ^ XOROUT, held stable until crc_valid & out_ready.
  - On that handshake: register = INIT, state IDLE.
  - in_ready = 0; in_valid is ignored.
- Latency: beat with in_last accepted at edge E; crc_valid is high after edge E+K.
- crc_out = 0 whenever crc_valid = 0.
- Single-beat frames (in_last on the first beat) are legal.
- The update is an LFSR over GF(2); no arithmetic carries.

Optional Feature:
- Macro CRC_CHECK_EN.
- Defined:
  - Adds parameter RESIDUE (default 0) and output crc_ok (1 bit).
  - crc_ok = (raw register == RESIDUE), qualified by crc_valid; 0 otherwise and in reset.
  - Used on the receive side after the transmitted CRC has been streamed through the engine.
- Undefined: no crc_ok port and no comparator.

Decomposition:
- Package crc_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - a reflect function parametrised by width;
  - a localparam helper for count width.
- One combinational sub-module, crc_step: inputs reg[CRC_W], bits[BPC]; output next reg; unrolled BPC times from POLY.

Test Plan:
- Defaults: bytes "123456789" (0x31..0x39), last on 0x39, out_ready = 1 -> crc_valid after 8 cycles in SHIFT, crc_out = 0x29B1.
- BPC = 8 same stream -> identical 0x29B1; each beat IDLE->SHIFT in 2 cycles.
- CRC_W = 32, POLY = 0x04C11DB7, INIT = XOROUT = 0xFFFFFFFF, REFIN = REFOUT = 1, same bytes -> 0xCBF43926.
- POLY = 0x8005, INIT = 0, REFIN = REFOUT = 1, "123456789" -> 0xBB3D.
- Hold out_ready = 0 for 5 cycles in DONE:
  - crc_out stable, in_ready = 0.
  - Then init mid-frame after 3 bytes, followed by full frame -> 0x29B1 (no carry-over).
- Reset pulse mid-SHIFT -> all outputs 0 immediately.
- CRC_CHECK_EN: stream "123456789",0x29,0xB1 -> crc_ok = 1; corrupt one bit -> crc_ok = 0.

Source files
------------

// File: rtl/crc_stream_engine_pkg.sv
// Shared types and helpers for the streaming CRC engine: FSM state encoding,
// counter width helper and a width-parametrised bit reversal.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of the per-beat fold counter; a one-step beat still needs one bit.
    function automatic int cnt_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] reflect(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_stream_engine_step.sv
// crc_step: combinational fold of BPC message bits into a CRC register.
// i_bits[BPC-1] is the first bit of the group to enter the register.
module crc_step
    import crc_pkg::*;
#(
    parameter int                 CRC_W = 16,
    parameter int                 BPC   = 1,
    parameter logic [CRC_W-1:0]   POLY  = 'h1021
) (
    input  logic [CRC_W-1:0] i_crc,
    input  logic [BPC-1:0]   i_bits,
    output logic [CRC_W-1:0] o_crc
);

    always_comb begin
        logic [CRC_W-1:0] w_v;
        logic             w_fb;
        w_v  = i_crc;
        w_fb = 1'b0;
        // Unrolled Galois LFSR: feedback is the outgoing MSB xor the incoming bit.
        for (int i = BPC - 1; i >= 0; i--) begin
            w_fb = w_v[CRC_W-1] ^ i_bits[i];
            w_v  = {w_v[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
        end
        o_crc = w_v;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: beat-serial CRC generator/checker with valid/ready input
// and output handshakes. Optional receive-side residue check under CRC_CHECK_EN.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = 'h1021,
    parameter logic [CRC_W-1:0] INIT   = 'hFFFF,
    parameter logic [CRC_W-1:0] XOROUT = 'h0000,
    parameter int               DIN_W  = 8,
    parameter int               BPC    = 1,
    parameter bit               REFIN  = 1'b0,
    parameter bit               REFOUT = 1'b0
`ifdef CRC_CHECK_EN
    ,
    parameter logic [CRC_W-1:0] RESIDUE = '0
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIN_W-1:0] in_data,
    input  logic             in_last,
    output logic             crc_valid,
    input  logic             out_ready,
    output logic [CRC_W-1:0] crc_out,
    output state_t           dbg_state
`ifdef CRC_CHECK_EN
    ,
    output logic             crc_ok
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and the offered payload is held
    // until that edge.

    localparam int             K     = DIN_W / BPC;
    localparam int             CNT_W = cnt_width(K);
    localparam logic [CNT_W-1:0] K_M1 = CNT_W'(K - 1);

    if (DIN_W % BPC != 0) begin : g_bpc_err
        $error("crc_stream_engine: DIN_W must be a multiple of BPC");
    end
    if (CRC_W < 8 || CRC_W > 32) begin : g_crcw_err
        $error("crc_stream_engine: CRC_W must be within 8..32");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIN_W-1:0]   r_beat;
    logic               r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic [CRC_W-1:0]   r_crc;
    logic               r_up;

    logic               w_accept;
    logic               w_step;
    logic               w_release;
    logic [BPC-1:0]     w_bits;
    logic [DIN_W-1:0]   w_beat_nxt;
    logic [CRC_W-1:0]   w_crc_nxt;
    logic [31:0]        w_refl;
    logic [CRC_W-1:0]   w_final;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        crc_valid   = 1'b0;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_release   = 1'b0;
        if (init) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    in_ready = r_up;
                    if (in_valid && r_up) begin
                        w_accept    = 1'b1;
                        w_state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    w_step = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = r_last ? DONE : IDLE;
                    end
                end
                DONE: begin
                    crc_valid = 1'b1;
                    if (out_ready) begin
                        w_release   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Select the next BPC message bits and advance the beat register.
    always_comb begin
        w_bits     = '0;
        w_beat_nxt = r_beat;
        if (REFIN) begin
            for (int i = 0; i < BPC; i++) begin
                w_bits[BPC-1-i] = r_beat[i];
            end
            w_beat_nxt = r_beat >> BPC;
        end else begin
            w_bits     = r_beat[DIN_W-1 -: BPC];
            w_beat_nxt = r_beat << BPC;
        end
    end

    crc_step #(
        .CRC_W (CRC_W),
        .BPC   (BPC),
        .POLY  (POLY)
    ) u_step (
        .i_crc  (r_crc),
        .i_bits (w_bits),
        .o_crc  (w_crc_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_crc  <= INIT;
            r_cnt  <= '0;
            r_beat <= '0;
            r_last <= 1'b0;
            r_up   <= 1'b0;
        end else begin
            r_up <= 1'b1;
            if (init) begin
                r_crc  <= INIT;
                r_cnt  <= '0;
                r_last <= 1'b0;
            end else if (w_accept) begin
                r_beat <= in_data;
                r_last <= in_last;
                r_cnt  <= K_M1;
            end else if (w_step) begin
                r_crc  <= w_crc_nxt;
                r_beat <= w_beat_nxt;
                r_cnt  <= r_cnt - CNT_W'(1);
            end else if (w_release) begin
                r_crc <= INIT;
            end
        end
    end

    assign w_refl    = reflect(32'(r_crc), CRC_W);
    assign w_final   = (REFOUT ? w_refl[CRC_W-1:0] : r_crc) ^ XOROUT;
    assign crc_out   = crc_valid ? w_final : '0;
    assign dbg_state = r_state;

`ifdef CRC_CHECK_EN
    // Residue compares the raw register, before reflection and XOR-out.
    assign crc_ok = crc_valid && (r_crc == RESIDUE);
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: four parameterisations driven one at a time,
// checked against a polynomial long-division reference model.
module tb_crc_stream_engine;
  import crc_pkg::*;

  typedef logic [7:0] byte_q_t [$];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        init_s      [4];
  logic        in_valid_s  [4];
  logic        in_last_s   [4];
  logic        out_ready_s [4];
  logic [7:0]  in_data_s   [4];
  logic        in_ready_s  [4];
  logic        crc_valid_s [4];
  logic [31:0] crc_out_s   [4];
  state_t      st_s        [4];
  logic [15:0] w_c0, w_c1, w_c3;
  logic [31:0] w_c2;
`ifdef CRC_CHECK_EN
  logic        crc_ok_s    [4];
  logic        last_ok;
`endif

  int checks = 0;
  int errors = 0;

  // Reference parameters per instance: 0 CCITT-FALSE bit-serial, 1 same 8 bits/clk,
  // 2 CRC-32, 3 CRC-16/ARC.
  int          kk    [4] = '{8, 1, 8, 8};
  int          mw    [4] = '{16, 16, 32, 16};
  logic [31:0] mpoly [4] = '{32'h1021, 32'h1021, 32'h04C11DB7, 32'h8005};
  logic [31:0] minit [4] = '{32'hFFFF, 32'hFFFF, 32'hFFFFFFFF, 32'h0};
  logic [31:0] mxor  [4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'h0};
  bit          mref  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  crc_stream_engine u_d0 (
    .clk(clk), .reset(reset), .init(init_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_s[0]), .in_data(in_data_s[0]), .in_last(in_last_s[0]),
    .crc_valid(crc_valid_s[0]), .out_ready(out_ready_s[0]), .crc_out(w_c0),
    .dbg_state(st_s[0])
`ifdef CRC_CHECK_EN
    , .crc_ok(crc_ok_s[0])
`endif
  );

  crc_stream_engine #(.BPC(8)) u_d1 (
    .clk(clk), .reset(reset), .init(init_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_s[1]), .in_data(in_data_s[1]), .in_last(in_last_s[1]),
    .crc_valid(crc_valid_s[1]), .out_ready(out_ready_s[1]), .crc_out(w_c1),
    .dbg_state(st_s[1])
`ifdef CRC_CHECK_EN
    , .crc_ok(crc_ok_s[1])
`endif
  );

  crc_stream_engine #(
    .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF),
    .REFIN(1'b1), .REFOUT(1'b1)
  ) u_d2 (
    .clk(clk), .reset(reset), .init(init_s[2]), .in_valid(in_valid_s[2]),
    .in_ready(in_ready_s[2]), .in_data(in_data_s[2]), .in_last(in_last_s[2]),
    .crc_valid(crc_valid_s[2]), .out_ready(out_ready_s[2]), .crc_out(w_c2),
    .dbg_state(st_s[2])
`ifdef CRC_CHECK_EN
    , .crc_ok(crc_ok_s[2])
`endif
  );

  crc_stream_engine #(
    .POLY(16'h8005), .INIT(16'h0000), .REFIN(1'b1), .REFOUT(1'b1)
  ) u_d3 (
    .clk(clk), .reset(reset), .init(init_s[3]), .in_valid(in_valid_s[3]),
    .in_ready(in_ready_s[3]), .in_data(in_data_s[3]), .in_last(in_last_s[3]),
    .crc_valid(crc_valid_s[3]), .out_ready(out_ready_s[3]), .crc_out(w_c3),
    .dbg_state(st_s[3])
`ifdef CRC_CHECK_EN
    , .crc_ok(crc_ok_s[3])
`endif
  );

  assign crc_out_s[0] = {16'h0, w_c0};
  assign crc_out_s[1] = {16'h0, w_c1};
  assign crc_out_s[2] = w_c2;
  assign crc_out_s[3] = {16'h0, w_c3};

  // ---------------- reference model ----------------
  // CRC as the remainder of the augmented message divided by the generator,
  // with INIT xored into the leading W bits of the augmented message.
  function automatic logic [31:0] model_crc(input int d, input byte_q_t msg);
    bit          s[$];
    int          w;
    int          nb;
    logic [32:0] gen;
    logic [31:0] r;
    logic [31:0] t;
    w   = mw[d];
    gen = (33'd1 << w) | {1'b0, mpoly[d]};
    foreach (msg[i]) begin
      for (int j = 0; j < 8; j++) s.push_back(mref[d] ? msg[i][j] : msg[i][7-j]);
    end
    nb = s.size();
    for (int j = 0; j < w; j++) s.push_back(1'b0);
    for (int j = 0; j < w; j++) s[j] = s[j] ^ minit[d][w-1-j];
    for (int i = 0; i < nb; i++) begin
      if (s[i]) begin
        for (int j = 0; j <= w; j++) s[i+j] = s[i+j] ^ gen[w-j];
      end
    end
    r = '0;
    for (int j = 0; j < w; j++) r[w-1-j] = s[nb+j];
    if (mref[d]) begin
      t = '0;
      for (int j = 0; j < w; j++) t[j] = r[w-1-j];
      r = t;
    end
    return r ^ mxor[d];
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int d, input logic [7:0] b, input logic l, output int waited);
    in_valid_s[d] = 1'b1;
    in_data_s[d]  = b;
    in_last_s[d]  = l;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready_s[d]) break;
      waited++;
      if (waited > 200) begin
        check("accept_timeout", in_ready_s[d], 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid_s[d] = 1'b0;
    in_last_s[d]  = 1'b0;
  endtask

  task automatic run_frame(input int d, input byte_q_t msg, input int hold,
                           input string tag, output logic [31:0] got);
    int          w;
    int          n;
    logic [31:0] exp;
    exp = model_crc(d, msg);
    out_ready_s[d] = 1'b0;
    for (int i = 0; i < msg.size(); i++) begin
      send_beat(d, msg[i], (i == msg.size() - 1), w);
      check({tag, "_state_shift"}, st_s[d], SHIFT);
      if (i > 0) check({tag, "_beat_gap"}, w, kk[d]);
    end
    n = 0;
    while (!crc_valid_s[d] && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, kk[d]);
    got = crc_out_s[d];
    check({tag, "_crc"}, got, exp);
`ifdef CRC_CHECK_EN
    last_ok = crc_ok_s[d];
    if (d <= 1) check({tag, "_crc_ok"}, crc_ok_s[d], (exp == 0));
`endif
    for (int c = 0; c < hold; c++) begin
      in_valid_s[d] = 1'b1;
      in_data_s[d]  = 8'($urandom_range(0, 255));
      tick();
      check({tag, "_hold_crc"}, crc_out_s[d], exp);
      check({tag, "_hold_valid"}, crc_valid_s[d], 1);
      check({tag, "_hold_ready"}, in_ready_s[d], 0);
    end
    in_valid_s[d]  = 1'b0;
    out_ready_s[d] = 1'b1;
    tick();
    out_ready_s[d] = 1'b0;
    check({tag, "_rel_valid"}, crc_valid_s[d], 0);
    check({tag, "_rel_out"}, crc_out_s[d], 0);
    check({tag, "_rel_state"}, st_s[d], IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    byte_q_t     std;
    byte_q_t     m;
    logic [31:0] got;
    int          w;
    int          n;
    std = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    reset = 1'b0;
    for (int d = 0; d < 4; d++) begin
      init_s[d] = 1'b0; in_valid_s[d] = 1'b0; in_last_s[d] = 1'b0;
      in_data_s[d] = 8'h00; out_ready_s[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check("rst_in_ready", in_ready_s[d], 0);
      check("rst_crc_valid", crc_valid_s[d], 0);
      check("rst_crc_out", crc_out_s[d], 0);
      check("rst_state", st_s[d], IDLE);
    end
    reset = 1'b1;
    tick();
    for (int d = 0; d < 4; d++) check("post_rst_in_ready", in_ready_s[d], 1);

    // Known check values.
    run_frame(0, std, 0, "d0_std", got);
    check("d0_ccitt_false", got, 32'h29B1);
    run_frame(1, std, 0, "d1_std", got);
    check("d1_ccitt_false", got, 32'h29B1);
    run_frame(2, std, 0, "d2_std", got);
    check("d2_crc32", got, 32'hCBF43926);
    run_frame(3, std, 0, "d3_std", got);
    check("d3_arc", got, 32'hBB3D);

    // Consumer stall in DONE with a beat offered meanwhile.
    run_frame(0, std, 5, "d0_hold", got);
    check("d0_hold_value", got, 32'h29B1);

    // init mid-frame while shifting, then init in IDLE with a beat offered.
    for (int i = 0; i < 3; i++) send_beat(0, std[i], 1'b0, w);
    init_s[0] = 1'b1; in_valid_s[0] = 1'b1; in_data_s[0] = 8'h55;
    #1;
    check("init_shift_ready", in_ready_s[0], 0);
    tick();
    init_s[0] = 1'b0; in_valid_s[0] = 1'b0;
    check("init_shift_state", st_s[0], IDLE);
    init_s[0] = 1'b1; in_valid_s[0] = 1'b1;
    #1;
    check("init_idle_ready", in_ready_s[0], 0);
    tick();
    init_s[0] = 1'b0; in_valid_s[0] = 1'b0;
    check("init_idle_state", st_s[0], IDLE);
    run_frame(0, std, 0, "d0_after_init", got);
    check("d0_after_init_value", got, 32'h29B1);

    // Single-beat frame parked in DONE, then aborted by init.
    send_beat(1, 8'hC3, 1'b1, w);
    n = 0;
    while (!crc_valid_s[1] && n < 50) begin tick(); n++; end
    m = '{8'hC3};
    check("d1_single_crc", crc_out_s[1], model_crc(1, m));
    init_s[1] = 1'b1;
    #1;
    check("init_done_valid", crc_valid_s[1], 0);
    tick();
    init_s[1] = 1'b0;
    check("init_done_state", st_s[1], IDLE);
    check("init_done_valid2", crc_valid_s[1], 0);

    // Asynchronous reset while d0 shifts and d1 holds a result.
    send_beat(1, 8'h3C, 1'b1, w);
    tick(); tick();
    check("d1_pre_rst_valid", crc_valid_s[1], 1);
    send_beat(0, 8'hA5, 1'b0, w);
    tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_d0_state", st_s[0], IDLE);
    check("arst_d0_ready", in_ready_s[0], 0);
    check("arst_d0_valid", crc_valid_s[0], 0);
    check("arst_d0_out", crc_out_s[0], 0);
    check("arst_d1_valid", crc_valid_s[1], 0);
    check("arst_d1_out", crc_out_s[1], 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("arst_release_ready", in_ready_s[0], 1);
    run_frame(0, std, 0, "d0_after_rst", got);
    check("d0_after_rst_value", got, 32'h29B1);

`ifdef CRC_CHECK_EN
    m = std;
    m.push_back(8'h29);
    m.push_back(8'hB1);
    run_frame(0, m, 0, "chk_good", got);
    check("chk_good_ok", last_ok, 1);
    m[10] = 8'hB0;
    run_frame(0, m, 0, "chk_bad", got);
    check("chk_bad_ok", last_ok, 0);
`endif

    // Randomised frames across all instances.
    for (int it = 0; it < 30; it++) begin
      int d;
      int len;
      d   = $urandom_range(0, 3);
      len = $urandom_range(1, 6);
      m   = {};
      for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
      run_frame(d, m, $urandom_range(0, 3), $sformatf("rnd%0d_d%0d", it, d), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
